// File: rtl/red_pitaya_pfd_pkg.sv
// Shared constants and types for the PFD / quadrature integrator.
// Holds mode encodings, quadrature state encodings and the default widths.
package red_pitaya_pfd_pkg;

    localparam int OUTW_DEF = 14;
    localparam int ISR_DEF  = 0;

    localparam logic MODE_EDGE = 1'b0;
    localparam logic MODE_QUAD = 1'b1;

    typedef enum logic [1:0] {
        QST_0 = 2'd0,
        QST_1 = 2'd1,
        QST_2 = 2'd2,
        QST_3 = 2'd3
    } qstate_e;

    // Gray-code level pair {I,Q} to position around the quadrature cycle.
    function automatic qstate_e quad_state(input logic i, input logic q);
        qstate_e st;
        case ({i, q})
            2'b00:   st = QST_0;
            2'b10:   st = QST_1;
            2'b11:   st = QST_2;
            default: st = QST_3;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/red_pitaya_pfd_step.sv
// Combinational step decoder for the PFD integrator.
// Turns edge flags or a quadrature state pair into -1/0/+1 and an illegal flag.
module red_pitaya_pfd_step
    import red_pitaya_pfd_pkg::*;
(
    input  logic              mode_i,
    input  logic              cur1_i,
    input  logic              cur2_i,
    input  logic              prv1_i,
    input  logic              prv2_i,
    input  logic              e1_i,
    input  logic              e2_i,
    output logic signed [1:0] step_o,
    output logic              illegal_o
);

    logic [1:0] cur_st;
    logic [1:0] prv_st;
    logic [1:0] diff;

    // Select edge-difference or quadrature-direction decoding
    always_comb begin
        step_o    = 2'sd0;
        illegal_o = 1'b0;
        cur_st    = quad_state(cur1_i, cur2_i);
        prv_st    = quad_state(prv1_i, prv2_i);
        diff      = cur_st - prv_st;
        if (mode_i == MODE_EDGE) begin
            case ({e1_i, e2_i})
                2'b10:   step_o = 2'sd1;
                2'b01:   step_o = -2'sd1;
                default: step_o = 2'sd0;
            endcase
        end else begin
            case (diff)
                2'd1:    step_o = 2'sd1;
                2'd3:    step_o = -2'sd1;
                2'd2:    illegal_o = 1'b1;
                default: step_o = 2'sd0;
            endcase
        end
    end

endmodule

// File: rtl/red_pitaya_pfd_integrator.sv
// Saturating PFD / quadrature up-down integrator.
// Define PFD_INPUT_SYNC_EN to add a 2-flop input synchroniser.
module red_pitaya_pfd_integrator
    import red_pitaya_pfd_pkg::*;
#(
    parameter int OUTW = OUTW_DEF,
    parameter int ISR  = ISR_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   s1,
    input  logic                   s2,
    input  logic                   mode_i,
    input  logic                   clear_i,
    output logic signed [OUTW-1:0] integral_o,
    output logic                   sat_o,
    output logic                   err_o
);

    localparam int AW = OUTW + ISR;
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW-1:0] ACC_ONE = AW'(1);

    logic in1;
    logic in2;

`ifdef PFD_INPUT_SYNC_EN
    localparam int VW = 4;

    logic [1:0] sy1_q, sy1_d;
    logic [1:0] sy2_q, sy2_d;

    assign sy1_d = {sy1_q[0], s1};
    assign sy2_d = {sy2_q[0], s2};

    // Two-flop synchroniser ahead of the sample registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sy1_q <= '0;
            sy2_q <= '0;
        end else begin
            sy1_q <= sy1_d;
            sy2_q <= sy2_d;
        end
    end

    assign in1 = sy1_q[1];
    assign in2 = sy2_q[1];
`else
    localparam int VW = 2;

    assign in1 = s1;
    assign in2 = s2;
`endif

    logic                 s1_q, s2_q;
    logic                 l1_q, l2_q;
    logic                 mode_q;
    logic [VW-1:0]        vld_q, vld_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic                 err_q, err_d;

    logic                 e1, e2;
    logic                 evt_en;
    logic                 mode_chg;
    logic signed [1:0]    step;
    logic                 illegal;

    assign e1       = s1_q & ~l1_q;
    assign e2       = s2_q & ~l2_q;
    assign evt_en   = vld_q[VW-1];
    assign mode_chg = (mode_q != mode_i);
    assign vld_d    = {vld_q[VW-2:0], 1'b1};

    red_pitaya_pfd_step u_step (
        .mode_i    (mode_q),
        .cur1_i    (s1_q),
        .cur2_i    (s2_q),
        .prv1_i    (l1_q),
        .prv2_i    (l2_q),
        .e1_i      (e1),
        .e2_i      (e2),
        .step_o    (step),
        .illegal_o (illegal)
    );

    // Sample pipeline; valid chain blocks events until history is real
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            l1_q   <= 1'b0;
            l2_q   <= 1'b0;
            mode_q <= MODE_EDGE;
            vld_q  <= '0;
        end else begin
            s1_q   <= in1;
            s2_q   <= in2;
            l1_q   <= s1_q;
            l2_q   <= s2_q;
            mode_q <= mode_i;
            vld_q  <= vld_d;
        end
    end

    // Clear > mode change > saturating count step
    always_comb begin
        acc_d = acc_q;
        err_d = 1'b0;
        if (clear_i) begin
            acc_d = '0;
        end else if (mode_chg) begin
            acc_d = '0;
        end else if (evt_en) begin
            err_d = illegal;
            if (step == 2'sd1 && acc_q != ACC_MAX) begin
                acc_d = acc_q + ACC_ONE;
            end else if (step == -2'sd1 && acc_q != ACC_MIN) begin
                acc_d = acc_q - ACC_ONE;
            end
        end
        sat_d = (acc_d == ACC_MAX) || (acc_d == ACC_MIN);
    end

    // Accumulator and status flags
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            err_q <= err_d;
        end
    end

    assign integral_o = acc_q[AW-1:ISR];
    assign sat_o      = sat_q;
    assign err_o      = err_q;

endmodule
